// File: rtl/starflux_pkg.sv
// Shared playfield definitions for the starflux game: grid geometry, projectile
// slot record, writer sweep states and the bitmap indexing used by every grid reader.
package starflux_pkg;

   localparam int GRID_W = 160;
   localparam int GRID_H = 120;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       dir;
      logic [7:0] x;
      logic [6:0] y;
   } slot_t;

   // Column-major pixel index: all H rows of column x are contiguous.
   function automatic int unsigned grid_index(input logic [7:0] x, input logic [6:0] y,
                                              input int unsigned h);
      return h * 32'(x) + 32'(y);
   endfunction

endpackage

// File: rtl/projectile_grid_writer_if.sv
// Fire-request / bitmap bus between game control, the projectile writer and the
// collision reader. The writer is the slave; game control drives the master side.
interface projectile_grid_writer_if
   import starflux_pkg::*;
#(
   parameter int W     = GRID_W,
   parameter int H     = GRID_H,
   parameter int SLOTS = 8
);
   localparam int CNT_W = $clog2(SLOTS + 1);

   logic             fire_user;
   logic [7:0]       user_x;
   logic [6:0]       user_y;
   logic             fire_enemy;
   logic [7:0]       enemy_x;
   logic [6:0]       enemy_y;
   logic [W*H-1:0]   grid;
   logic             busy;
   logic             fire_drop;
   logic [CNT_W-1:0] active_count;

   modport master (
      output fire_user, user_x, user_y, fire_enemy, enemy_x, enemy_y,
      input  grid, busy, fire_drop, active_count
   );

   modport slave (
      input  fire_user, user_x, user_y, fire_enemy, enemy_x, enemy_y,
      output grid, busy, fire_drop, active_count
   );

endinterface

// File: rtl/rate_divider.sv
// Free-running countdown; q sweeps countdown_start-1 down to 0, so q == 0 occurs
// once every countdown_start cycles.
module rate_divider #(
   parameter int WIDTH = 22
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] countdown_start,
   output logic [WIDTH-1:0] q
);

   // Countdown register with reload on zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         q <= countdown_start - WIDTH'(1);
      end else if (q == '0) begin
         q <= countdown_start - WIDTH'(1);
      end else begin
         q <= q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/projectile_grid_writer.sv
// Projectile pool and bitmap owner: spawns fire requests into free slots and, on each
// movement tick, erases all projectiles then redraws them one pixel further along.
module projectile_grid_writer
   import starflux_pkg::*;
#(
   parameter int W           = GRID_W,
   parameter int H           = GRID_H,
   parameter int SLOTS       = 8,
   parameter int TICK_CYCLES = 3_125_000
) (
   input  logic                    clock,
   input  logic                    reset,
   projectile_grid_writer_if.slave bus
);

   localparam int IDX_W  = $clog2(W * H);
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int CNT_W  = $clog2(SLOTS + 1);
   localparam int TICK_W = $clog2(TICK_CYCLES + 1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   state_t             state_r, state_next_s;
   slot_t              slots_r [SLOTS];
   slot_t              cur_s, slot_wdata_s;
   logic [W*H-1:0]     grid_r;
   logic [SLOT_W-1:0]  idx_r, free_idx_s, slot_widx_s;
   logic [IDX_W-1:0]   grid_widx_s;
   logic [CNT_W-1:0]   active_count_r, valid_count_s;
   logic [TICK_W-1:0]  tick_q_s;
   logic [7:0]         pend_user_x_r, pend_enemy_x_r, spawn_x_s;
   logic [6:0]         pend_user_y_r, pend_enemy_y_r, spawn_y_s, new_y_s;
   logic tick_pending_r, busy_r, fire_drop_r, pend_user_r, pend_enemy_r;
   logic take_tick_s, spawn_s, spawn_dir_s, spawn_ok_s, spawn_drop_s, free_found_s;
   logic user_direct_s, enemy_direct_s, user_clr_s, enemy_clr_s, exit_s;
   logic grid_we_s, grid_wval_s, slot_we_s;
   logic user_defer_s, enemy_defer_s;

   rate_divider #(.WIDTH(TICK_W)) tick_gen (
      .clock           (clock),
      .reset           (reset),
      .countdown_start (TICK_W'(TICK_CYCLES)),
      .q               (tick_q_s)
   );

   // A pulse not consumed directly this cycle must wait in its pending register.
   assign user_defer_s  = bus.fire_user  & ~user_direct_s;
   assign enemy_defer_s = bus.fire_enemy & ~enemy_direct_s;
   assign spawn_ok_s    = (32'(spawn_x_s) < W) && (32'(spawn_y_s) < H) && free_found_s;

   // Lowest free slot and occupancy count.
   always_comb begin
      free_found_s  = 1'b0;
      free_idx_s    = '0;
      valid_count_s = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         valid_count_s = valid_count_s + CNT_W'(slots_r[i].valid);
         if (!slots_r[i].valid) begin
            free_found_s = 1'b1;
            free_idx_s   = SLOT_W'(i);
         end else begin
            free_found_s = free_found_s;
         end
      end
   end

   // Next position of the slot under the sweep pointer.
   always_comb begin
      cur_s = slots_r[idx_r];
      if (cur_s.dir == DIR_DOWN) begin
         exit_s  = (32'(cur_s.y) == 32'(H - 1));
         new_y_s = cur_s.y + 7'd1;
      end else begin
         exit_s  = (cur_s.y == 7'd0);
         new_y_s = cur_s.y - 7'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state, tick acceptance and spawn arbitration (user ahead of enemy).
   always_comb begin
      state_next_s   = state_r;
      take_tick_s    = 1'b0;
      spawn_s        = 1'b0;
      spawn_dir_s    = DIR_UP;
      spawn_x_s      = 8'd0;
      spawn_y_s      = 7'd0;
      user_direct_s  = 1'b0;
      enemy_direct_s = 1'b0;
      user_clr_s     = 1'b0;
      enemy_clr_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (tick_pending_r) begin
               take_tick_s  = 1'b1;
               state_next_s = ERASE;
            end else if (bus.fire_user || pend_user_r) begin
               spawn_s     = 1'b1;
               spawn_dir_s = DIR_UP;
               if (pend_user_r) begin
                  spawn_x_s  = pend_user_x_r;
                  spawn_y_s  = pend_user_y_r;
                  user_clr_s = 1'b1;
               end else begin
                  spawn_x_s     = bus.user_x;
                  spawn_y_s     = bus.user_y;
                  user_direct_s = 1'b1;
               end
            end else if (bus.fire_enemy || pend_enemy_r) begin
               spawn_s     = 1'b1;
               spawn_dir_s = DIR_DOWN;
               if (pend_enemy_r) begin
                  spawn_x_s   = pend_enemy_x_r;
                  spawn_y_s   = pend_enemy_y_r;
                  enemy_clr_s = 1'b1;
               end else begin
                  spawn_x_s      = bus.enemy_x;
                  spawn_y_s      = bus.enemy_y;
                  enemy_direct_s = 1'b1;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         ERASE: begin
            if (idx_r == LAST_SLOT) begin
               state_next_s = DRAW;
            end else begin
               state_next_s = ERASE;
            end
         end
         DRAW: begin
            if (idx_r == LAST_SLOT) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DRAW;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Single grid-bit and slot write port shared by spawn, erase and draw.
   always_comb begin
      grid_we_s    = 1'b0;
      grid_widx_s  = '0;
      grid_wval_s  = 1'b0;
      slot_we_s    = 1'b0;
      slot_widx_s  = '0;
      slot_wdata_s = cur_s;
      spawn_drop_s = 1'b0;
      if (spawn_s) begin
         if (spawn_ok_s) begin
            grid_we_s    = 1'b1;
            grid_widx_s  = IDX_W'(grid_index(spawn_x_s, spawn_y_s, H));
            grid_wval_s  = 1'b1;
            slot_we_s    = 1'b1;
            slot_widx_s  = free_idx_s;
            slot_wdata_s = '{valid: 1'b1, dir: spawn_dir_s, x: spawn_x_s, y: spawn_y_s};
         end else begin
            spawn_drop_s = 1'b1;
         end
      end else if (state_r == ERASE && cur_s.valid) begin
         grid_we_s   = 1'b1;
         grid_widx_s = IDX_W'(grid_index(cur_s.x, cur_s.y, H));
         grid_wval_s = 1'b0;
      end else if (state_r == DRAW && cur_s.valid) begin
         slot_we_s   = 1'b1;
         slot_widx_s = idx_r;
         if (exit_s) begin
            slot_wdata_s.valid = 1'b0;
         end else begin
            slot_wdata_s.y = new_y_s;
            grid_we_s      = 1'b1;
            grid_widx_s    = IDX_W'(grid_index(cur_s.x, new_y_s, H));
            grid_wval_s    = 1'b1;
         end
      end else begin
         grid_we_s = 1'b0;
      end
   end

   // Datapath: bitmap, slots, sweep pointer, pending requests and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         grid_r         <= '0;
         idx_r          <= '0;
         tick_pending_r <= 1'b0;
         busy_r         <= 1'b0;
         fire_drop_r    <= 1'b0;
         active_count_r <= '0;
         pend_user_r    <= 1'b0;
         pend_enemy_r   <= 1'b0;
         pend_user_x_r  <= 8'd0;
         pend_user_y_r  <= 7'd0;
         pend_enemy_x_r <= 8'd0;
         pend_enemy_y_r <= 7'd0;
         for (int i = 0; i < SLOTS; i++) begin
            slots_r[i] <= '0;
         end
      end else begin
         busy_r         <= (state_next_s != IDLE);
         fire_drop_r    <= spawn_drop_s | (user_defer_s & pend_user_r) | (enemy_defer_s & pend_enemy_r);
         active_count_r <= valid_count_s;
         tick_pending_r <= (tick_q_s == '0) | (tick_pending_r & ~take_tick_s);
         if (take_tick_s || state_r == IDLE) begin
            idx_r <= '0;
         end else begin
            idx_r <= (idx_r == LAST_SLOT) ? '0 : idx_r + SLOT_W'(1);
         end
         if (grid_we_s) begin
            grid_r[grid_widx_s] <= grid_wval_s;
         end
         if (slot_we_s) begin
            slots_r[slot_widx_s] <= slot_wdata_s;
         end
         if (user_defer_s && !pend_user_r) begin
            pend_user_r   <= 1'b1;
            pend_user_x_r <= bus.user_x;
            pend_user_y_r <= bus.user_y;
         end else if (user_clr_s) begin
            pend_user_r <= 1'b0;
         end
         if (enemy_defer_s && !pend_enemy_r) begin
            pend_enemy_r   <= 1'b1;
            pend_enemy_x_r <= bus.enemy_x;
            pend_enemy_y_r <= bus.enemy_y;
         end else if (enemy_clr_s) begin
            pend_enemy_r <= 1'b0;
         end
      end
   end

   assign bus.grid         = grid_r;
   assign bus.busy         = busy_r;
   assign bus.fire_drop    = fire_drop_r;
   assign bus.active_count = active_count_r;

endmodule

// File: tb/tb_projectile_grid_writer.sv
// Directed bench for projectile_grid_writer with a 40-cycle tick and 8 slots.
module tb_projectile_grid_writer;
   import starflux_pkg::*;

   localparam int HH = 120;

   logic clock;
   logic reset;
   int   errors;
   int   checks;

   projectile_grid_writer_if #(.W(160), .H(120), .SLOTS(8)) bus ();

   projectile_grid_writer #(.W(160), .H(120), .SLOTS(8), .TICK_CYCLES(40)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic idle_inputs();
      bus.fire_user  = 1'b0;
      bus.fire_enemy = 1'b0;
      bus.user_x     = 8'd0;
      bus.user_y     = 7'd0;
      bus.enemy_x    = 8'd0;
      bus.enemy_y    = 7'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulse_user(input logic [7:0] x, input logic [6:0] y);
      bus.fire_user = 1'b1;
      bus.user_x    = x;
      bus.user_y    = y;
      @(negedge clock);
      bus.fire_user = 1'b0;
   endtask

   task automatic pulse_enemy(input logic [7:0] x, input logic [6:0] y);
      bus.fire_enemy = 1'b1;
      bus.enemy_x    = x;
      bus.enemy_y    = y;
      @(negedge clock);
      bus.fire_enemy = 1'b0;
   endtask

   // Waits for the next sweep and returns how many cycles busy stayed high.
   task automatic wait_sweep(output int hi, output bit ok);
      int n;
      n  = 0;
      hi = 0;
      while (bus.busy !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      ok = (bus.busy === 1'b1);
      while (bus.busy === 1'b1 && hi < 100) begin
         @(negedge clock);
         hi++;
      end
      ok = ok && (bus.busy === 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.grid !== '0) begin
         errors++; $display("FAIL reset_grid: got nonzero grid, expected all zero");
      end
      checks++;
      if ({bus.busy, bus.fire_drop, bus.active_count} !== 6'd0) begin
         errors++; $display("FAIL reset_status: got busy=%b drop=%b count=%0d expected 0/0/0",
                            bus.busy, bus.fire_drop, bus.active_count);
      end
   endtask

   task automatic test_user_move();
      int hi; bit ok;
      do_reset();
      pulse_user(8'd10, 7'd50);
      checks++;
      if (bus.grid[HH*10+50] !== 1'b1) begin
         errors++; $display("FAIL spawn_bit: got %b expected 1", bus.grid[HH*10+50]);
      end
      @(negedge clock);
      checks++;
      if (bus.active_count !== 4'd1) begin
         errors++; $display("FAIL count_one: got %0d expected 1", bus.active_count);
      end
      wait_sweep(hi, ok);
      checks++;
      if (!ok || hi != 16) begin
         errors++; $display("FAIL busy_len: got %0d cycles (ok=%0d) expected 16", hi, ok);
      end
      checks++;
      if ({bus.grid[HH*10+50], bus.grid[HH*10+49]} !== 2'b01) begin
         errors++; $display("FAIL moved_up: got old=%b new=%b expected old=0 new=1",
                            bus.grid[HH*10+50], bus.grid[HH*10+49]);
      end
   endtask

   task automatic test_exit();
      int hi; bit ok;
      do_reset();
      pulse_enemy(8'd5, 7'd119);
      checks++;
      if (bus.grid[719] !== 1'b1) begin
         errors++; $display("FAIL enemy_spawn: got %b expected 1", bus.grid[719]);
      end
      wait_sweep(hi, ok);
      checks++;
      if (!ok || bus.grid !== '0 || bus.active_count !== 4'd0) begin
         errors++; $display("FAIL enemy_exit: got bit=%b count=%0d ok=%0d expected 0/0/1",
                            bus.grid[719], bus.active_count, ok);
      end
      do_reset();
      pulse_user(8'd7, 7'd0);
      wait_sweep(hi, ok);
      checks++;
      if (!ok || bus.grid !== '0 || bus.active_count !== 4'd0) begin
         errors++; $display("FAIL user_exit: got bit=%b count=%0d ok=%0d expected 0/0/1",
                            bus.grid[840], bus.active_count, ok);
      end
   endtask

   task automatic test_coincident();
      do_reset();
      bus.fire_user  = 1'b1; bus.user_x  = 8'd20; bus.user_y  = 7'd60;
      bus.fire_enemy = 1'b1; bus.enemy_x = 8'd30; bus.enemy_y = 7'd10;
      @(negedge clock);
      idle_inputs();
      checks++;
      if ({bus.grid[2460], bus.grid[3610], bus.fire_drop} !== 3'b100) begin
         errors++; $display("FAIL coincident_n1: got user=%b enemy=%b drop=%b expected 1/0/0",
                            bus.grid[2460], bus.grid[3610], bus.fire_drop);
      end
      @(negedge clock);
      checks++;
      if ({bus.grid[2460], bus.grid[3610], bus.fire_drop} !== 3'b110) begin
         errors++; $display("FAIL coincident_n2: got user=%b enemy=%b drop=%b expected 1/1/0",
                            bus.grid[2460], bus.grid[3610], bus.fire_drop);
      end
   endtask

   task automatic test_pool_full();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         pulse_user(8'(i), 7'd100);
         checks++;
         if (bus.grid[HH*i+100] !== (i < 8) || bus.fire_drop !== (i == 8)) begin
            errors++; $display("FAIL pool_fill_%0d: got bit=%b drop=%b expected %0d/%0d",
                               i, bus.grid[HH*i+100], bus.fire_drop, i < 8, i == 8);
         end
         @(negedge clock);
      end
      checks++;
      if (bus.active_count !== 4'd8 || bus.fire_drop !== 1'b0) begin
         errors++; $display("FAIL pool_count: got %0d drop=%b expected 8/0",
                            bus.active_count, bus.fire_drop);
      end
   endtask

   task automatic test_out_of_range();
      do_reset();
      pulse_user(8'd160, 7'd5);
      checks++;
      if (bus.fire_drop !== 1'b1 || bus.grid !== '0) begin
         errors++; $display("FAIL oor_x: got drop=%b expected 1 and empty grid", bus.fire_drop);
      end
      @(negedge clock);
      pulse_enemy(8'd3, 7'd120);
      checks++;
      if (bus.fire_drop !== 1'b1 || bus.grid !== '0) begin
         errors++; $display("FAIL oor_y: got drop=%b expected 1 and empty grid", bus.fire_drop);
      end
      @(negedge clock);
      checks++;
      if (bus.active_count !== 4'd0 || bus.fire_drop !== 1'b0) begin
         errors++; $display("FAIL oor_count: got %0d drop=%b expected 0/0",
                            bus.active_count, bus.fire_drop);
      end
   endtask

   task automatic test_overlap();
      int hi; bit ok;
      do_reset();
      pulse_user(8'd40, 7'd40);
      pulse_enemy(8'd40, 7'd40);
      wait_sweep(hi, ok);
      checks++;
      if (!ok || {bus.grid[HH*40+39], bus.grid[HH*40+40], bus.grid[HH*40+41]} !== 3'b101) begin
         errors++; $display("FAIL overlap: got 39/40/41=%b%b%b ok=%0d expected 101",
                            bus.grid[HH*40+39], bus.grid[HH*40+40], bus.grid[HH*40+41], ok);
      end
   endtask

   task automatic test_busy_fire_and_reset();
      int n;
      do_reset();
      n = 0;
      while (bus.busy !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      pulse_user(8'd50, 7'd60);
      checks++;
      if (bus.busy !== 1'b1 || bus.grid[6060] !== 1'b0) begin
         errors++; $display("FAIL busy_defer: got busy=%b bit=%b expected 1/0",
                            bus.busy, bus.grid[6060]);
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin @(negedge clock); n++; end
      checks++;
      if (bus.busy !== 1'b0 || bus.grid[6060] !== 1'b0) begin
         errors++; $display("FAIL pend_early: got busy=%b bit=%b expected 0/0",
                            bus.busy, bus.grid[6060]);
      end
      @(negedge clock);
      checks++;
      if (bus.grid[6060] !== 1'b1) begin
         errors++; $display("FAIL pend_service: got %b expected 1", bus.grid[6060]);
      end
      n = 0;
      while (bus.busy !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.grid !== '0 || bus.busy !== 1'b0 || n >= 200) begin
         errors++; $display("FAIL mid_sweep_reset: got busy=%b grid_zero=%b wait=%0d expected 0/1/<200",
                            bus.busy, bus.grid == '0, n);
      end
      reset = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_user_move();
      test_exit();
      test_coincident();
      test_pool_full();
      test_out_of_range();
      test_overlap();
      test_busy_fire_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
